// File: rtl/serial_to_parallel_converter_if.sv
// Handshake bundle for the serial-to-parallel converter: serial bit stream in, parallel word out.
// The slave modport is the converter's view, the master modport is the driver/consumer's view.
interface serial_to_parallel_converter_if #(
    parameter int N = 8
);
    logic         ser_data;
    logic         ser_valid;
    logic         ser_ready;
    logic [N-1:0] par_data;
    logic         par_valid;
    logic         par_ready;

    modport slave (
        input  ser_data,
        input  ser_valid,
        output ser_ready,
        output par_data,
        output par_valid,
        input  par_ready
    );

    modport master (
        output ser_data,
        output ser_valid,
        input  ser_ready,
        input  par_data,
        input  par_valid,
        output par_ready
    );
endinterface

// File: rtl/serial_to_parallel_converter.sv
// Assembles N handshaked serial bits into a word, double-buffered: a shift register keeps
// filling while the previous word waits in the output register for par_ready.
module serial_to_parallel_converter #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    serial_to_parallel_converter_if.slave  bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [N-1:0]  sh_r;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  par_data_r;
    logic          par_valid_r;

    logic          ser_ready_s;
    logic          accept_s;
    logic          complete_s;
    logic          slot_free_s;
    logic [N-1:0]  sh_shifted_s;
    logic [N-1:0]  word_s;
    logic [N-1:0]  sh_next_s;
    logic [CW-1:0] cnt_next_s;
    logic [N-1:0]  par_data_next_s;
    logic          par_valid_next_s;

    // A full count means a word is parked in the shift register, so no more bits are taken.
    assign ser_ready_s = !rst && (cnt_r < CNT_FULL);
    assign accept_s    = bus.ser_valid && ser_ready_s;
    assign slot_free_s = !par_valid_r || bus.par_ready;
    assign complete_s  = (accept_s && (cnt_r == CNT_LAST)) || (cnt_r == CNT_FULL);

    // Next-state logic for the shift register, bit count and output slot.
    always_comb begin
        sh_shifted_s     = sh_r;
        word_s           = sh_r;
        sh_next_s        = sh_r;
        cnt_next_s       = cnt_r;
        par_data_next_s  = par_data_r;
        par_valid_next_s = par_valid_r;

        if (MSB_FIRST) begin
            sh_shifted_s = {sh_r[N-2:0], bus.ser_data};
        end else begin
            sh_shifted_s = {bus.ser_data, sh_r[N-1:1]};
        end

        if (accept_s) begin
            sh_next_s  = sh_shifted_s;
            cnt_next_s = cnt_r + CW'(1);
            word_s     = sh_shifted_s;
        end else begin
            sh_next_s  = sh_r;
            cnt_next_s = cnt_r;
            word_s     = sh_r;
        end

        // A complete word that cannot move yet stays parked with cnt held at N.
        if (complete_s && slot_free_s) begin
            par_data_next_s  = word_s;
            par_valid_next_s = 1'b1;
            cnt_next_s       = {CW{1'b0}};
        end else if (par_valid_r && bus.par_ready) begin
            par_valid_next_s = 1'b0;
        end else begin
            par_valid_next_s = par_valid_r;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_r        <= {N{1'b0}};
            cnt_r       <= {CW{1'b0}};
            par_data_r  <= {N{1'b0}};
            par_valid_r <= 1'b0;
        end else begin
            sh_r        <= sh_next_s;
            cnt_r       <= cnt_next_s;
            par_data_r  <= par_data_next_s;
            par_valid_r <= par_valid_next_s;
        end
    end

    assign bus.ser_ready = ser_ready_s;
    assign bus.par_data  = par_data_r;
    assign bus.par_valid = par_valid_r;
endmodule

// File: tb/tb_serial_to_parallel_converter.sv
// Directed bench: an N=8 MSB-first converter and an N=4 LSB-first converter on one clock.
module tb_serial_to_parallel_converter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_to_parallel_converter_if #(.N(8)) a_if ();
    serial_to_parallel_converter_if #(.N(4)) b_if ();

    serial_to_parallel_converter #(.N(8), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    serial_to_parallel_converter #(.N(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic b);
        a_if.ser_data  = b;
        a_if.ser_valid = 1'b1;
        tick();
        a_if.ser_valid = 1'b0;
    endtask

    task automatic send_b(input logic b);
        b_if.ser_data  = b;
        b_if.ser_valid = 1'b1;
        tick();
        b_if.ser_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] w8;
        logic [3:0] w4;
        logic [3:0] stream [3];
        total = 0;
        bad   = 0;
        stream[0] = 4'h9;
        stream[1] = 4'h6;
        stream[2] = 4'hC;

        rst            = 1'b1;
        a_if.ser_data  = 1'b1;
        a_if.ser_valid = 1'b1;
        a_if.par_ready = 1'b1;
        b_if.ser_data  = 1'b0;
        b_if.ser_valid = 1'b0;
        b_if.par_ready = 1'b1;

        // Reset held two cycles with ser_valid high.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_par_valid", 32'(a_if.par_valid), 32'd0);
            chk("rst_par_data", 32'(a_if.par_data), 32'd0);
            chk("rst_ser_ready", 32'(a_if.ser_ready), 32'd0);
        end
        rst            = 1'b0;
        a_if.ser_valid = 1'b0;
        #1;
        chk("post_rst_ser_ready", 32'(a_if.ser_ready), 32'd1);
        tick();
        chk("post_rst_par_valid", 32'(a_if.par_valid), 32'd0);

        // Basic word 62, MSB first.
        w8 = 8'd62;
        for (int i = 7; i >= 0; i--) begin
            send_a(w8[i]);
            if (i != 0) chk("basic_early_valid", 32'(a_if.par_valid), 32'd0);
        end
        chk("basic_valid", 32'(a_if.par_valid), 32'd1);
        chk("basic_data", 32'(a_if.par_data), 32'd62);
        tick();
        chk("basic_one_cycle", 32'(a_if.par_valid), 32'd0);

        // Word 52 with a 3-cycle gap after bit 4 and toggling ser_data.
        w8 = 8'd52;
        for (int i = 7; i >= 4; i--) send_a(w8[i]);
        for (int g = 0; g < 3; g++) begin
            a_if.ser_data = ~a_if.ser_data;
            tick();
            chk("gap_valid", 32'(a_if.par_valid), 32'd0);
        end
        for (int i = 3; i >= 0; i--) send_a(w8[i]);
        chk("gap_valid_out", 32'(a_if.par_valid), 32'd1);
        chk("gap_data", 32'(a_if.par_data), 32'd52);
        tick();
        chk("gap_one_cycle", 32'(a_if.par_valid), 32'd0);

        // Backpressure: 7 then 52 back-to-back with par_ready low.
        a_if.par_ready = 1'b0;
        w8 = 8'd7;
        for (int i = 7; i >= 0; i--) send_a(w8[i]);
        chk("bp_first_valid", 32'(a_if.par_valid), 32'd1);
        chk("bp_first_data", 32'(a_if.par_data), 32'd7);
        w8 = 8'd52;
        for (int i = 7; i >= 0; i--) begin
            send_a(w8[i]);
            chk("bp_hold_data", 32'(a_if.par_data), 32'd7);
            chk("bp_hold_valid", 32'(a_if.par_valid), 32'd1);
        end
        chk("bp_ser_ready_low", 32'(a_if.ser_ready), 32'd0);
        a_if.ser_data  = 1'b1;
        a_if.ser_valid = 1'b1;
        tick();
        chk("bp_parked_data", 32'(a_if.par_data), 32'd7);
        chk("bp_parked_ready", 32'(a_if.ser_ready), 32'd0);
        a_if.ser_valid = 1'b0;
        a_if.par_ready = 1'b1;
        tick();
        a_if.par_ready = 1'b0;
        chk("bp_second_data", 32'(a_if.par_data), 32'd52);
        chk("bp_second_valid", 32'(a_if.par_valid), 32'd1);
        chk("bp_ser_ready_back", 32'(a_if.ser_ready), 32'd1);
        tick();
        chk("bp_second_hold", 32'(a_if.par_valid), 32'd1);
        a_if.par_ready = 1'b1;
        tick();
        chk("bp_drain_valid", 32'(a_if.par_valid), 32'd0);
        chk("bp_drain_data_kept", 32'(a_if.par_data), 32'd52);

        // Reset mid-frame discards the partial F0 word.
        for (int i = 0; i < 4; i++) send_a(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(a_if.par_valid), 32'd0);
        chk("midrst_data", 32'(a_if.par_data), 32'd0);
        w8 = 8'd7;
        for (int i = 7; i >= 0; i--) begin
            send_a(w8[i]);
            if (i != 0) chk("midrst_early_valid", 32'(a_if.par_valid), 32'd0);
        end
        chk("midrst_word_valid", 32'(a_if.par_valid), 32'd1);
        chk("midrst_word_data", 32'(a_if.par_data), 32'd7);
        tick();

        // LSB-first, N=4: bits 1,0,0,0 give 4'h1.
        send_b(1'b1);
        send_b(1'b0);
        send_b(1'b0);
        send_b(1'b0);
        chk("lsb_valid", 32'(b_if.par_valid), 32'd1);
        chk("lsb_data", 32'(b_if.par_data), 32'd1);

        // Continuous stream of three words with par_ready high.
        b_if.ser_valid = 1'b1;
        for (int w = 0; w < 3; w++) begin
            w4 = stream[w];
            for (int i = 0; i < 4; i++) begin
                b_if.ser_data  = w4[i];
                b_if.ser_valid = 1'b1;
                tick();
                chk("stream_ser_ready", 32'(b_if.ser_ready), 32'd1);
                chk("stream_valid", 32'(b_if.par_valid), (i == 3) ? 32'd1 : 32'd0);
                if (i == 3) chk("stream_data", 32'(b_if.par_data), 32'(w4));
            end
        end
        b_if.ser_valid = 1'b0;
        tick();
        chk("stream_end_valid", 32'(b_if.par_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
